// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice plus a carry flip-flop, fed LSB first.
// {cout,sum} = a + b + cin, with a one-cycle done pulse WIDTH+1 cycles after start is taken.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sum_bit_s;
  logic             carry_nxt_s;

  // Full-adder bit-slice on the current LSB pair and the stored carry
  always_comb begin
    sum_bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt_s = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          count_d = {CW{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {sum_bit_s, sum_q[WIDTH-1:1]};
        carry_d = carry_nxt_s;
        count_d = count_q + CNT_ONE;
        // The final shift also latches the carry-out alongside the last sum bit
        if (count_q == CNT_LAST) begin
          cout_d  = carry_nxt_s;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SHIFT) || (state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      count_q <= {CW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against a queued a+b+cin reference.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W:0]   exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Pops the oldest expectation and compares it with the current result
  task automatic check_result(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({cout, sum}), 32'(e));
    end
  endtask

  // One full transaction: one-cycle start, latency/busy/pulse-width checks, result check
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    exp_q.push_back(ref_add(ta, tb_, tc));
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    chk("latency", 32'(lat), 32'd9);
    chk("busy_cycles", 32'(bcnt), 32'd9);
    check_result("result");
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    int last_done;
    logic [W:0] held;

    reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    reset = 1'b0; start = 1'b0;

    // Directed arithmetic cases
    run_op(8'h5A, 8'h3C, 1'b0);
    held = {cout, sum};
    repeat (3) @(negedge clk);
    chk("sum_hold", 32'({cout, sum}), 32'(held));
    chk("sum_hold_value", 32'({cout, sum}), 32'h096);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b1);

    // Start pulsed mid-transaction is ignored
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    exp_q.push_back(ref_add(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (2) begin @(negedge clk); lat++; end
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("ignore_latency", 32'(lat), 32'd9);
    check_result("ignore_result");
    @(negedge clk);
    chk("ignore_no_restart", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT aborts without a done pulse
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    seen = 0;
    repeat (15) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Start held high: back-to-back adds every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h81; b = 8'h81; cin = 1'b0;
    repeat (3) exp_q.push_back(ref_add(8'h81, 8'h81, 1'b0));
    lat = 0; seen = 0; last_done = 0;
    while (seen < 3 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen++;
        check_result("held_result");
        chk("held_period", 32'(lat - last_done), (seen == 1) ? 32'd9 : 32'd10);
        last_done = lat;
      end
    end
    start = 1'b0;
    chk("held_count", 32'(seen), 32'd3);
    repeat (3) @(negedge clk);
    chk("held_idle", 32'(busy), 32'd0);
    exp_q.delete();

    // Random scoreboard traffic
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
